regfile_dump: RTL

- Debug readout engine for the 8-entry, 32-bit CPU register file.
- Drives one register-file read address and snapshots the returned word.
- Streams each register out as a framed byte sequence over an 8-bit valid/ready port toward the TinyTapeout output pins.
- Lets the bench or host read architectural state without disturbing the core's write port.

---
 rtl/regfile_dump.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - register file readout engine streaming framed bytes
module regfile_dump #(
    parameter int         NREGS = 8,
    parameter int         DW    = 32,
    parameter logic [4:0] HDR   = 5'b10100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    lo_reg,
    input  logic [2:0]    hi_reg,
    output logic [2:0]    ra,
    input  logic [DW-1:0] rd,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [2:0]      idx;
    logic [2:0]      end_idx;
    logic [2:0]      cnt;
    logic [DW-1:0]   snap;
    logic [2:0]      ra_q;
    logic            done_q;

    logic            fire;
    logic            last_byte;
    logic            at_end;
    logic [2:0]      idx_inc;

    assign fire      = (state == SEND) && out_ready;
    assign last_byte = (cnt == 3'd4);
    assign at_end    = (idx == end_idx);
    assign idx_inc   = (idx == 3'(NREGS - 1)) ? 3'd0 : idx + 3'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: one LOAD cycle per register, five SEND bytes each
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = LOAD;
            LOAD: state_nx = SEND;
            SEND: if (fire && last_byte) state_nx = at_end ? IDLE : LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: range latch, snapshot capture, byte counter and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= 3'd0;
            end_idx <= 3'd0;
            cnt     <= 3'd0;
            snap    <= '0;
            ra_q    <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= fire && last_byte && at_end;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= lo_reg;
                        end_idx <= hi_reg;
                    end
                end
                LOAD: begin
                    snap <= rd;
                    cnt  <= 3'd0;
                    ra_q <= idx;
                end
                SEND: begin
                    if (fire) begin
                        if (!last_byte) begin
                            cnt <= cnt + 3'd1;
                        end else if (!at_end) begin
                            idx <= idx_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: read address follows idx only in LOAD, stream byte muxed from snapshot
    always_comb begin
        ra        = (state == LOAD) ? idx : ra_q;
        busy      = (state != IDLE);
        out_valid = (state == SEND);
        out_last  = (state == SEND) && last_byte && at_end;
        done      = done_q;
        out_data  = 8'd0;
        if (state == SEND) begin
            case (cnt)
                3'd0:    out_data = {HDR, idx};
                3'd1:    out_data = snap[7:0];
                3'd2:    out_data = snap[15:8];
                3'd3:    out_data = snap[23:16];
                3'd4:    out_data = snap[31:24];
                default: out_data = 8'd0;
            endcase
        end
    end

endmodule
